// File: rtl/lif_tdm_scheduler_if.sv
// Sample-input and spike-event signals shared by the pin wrapper, the LIF
// scheduler and downstream spike consumers.
interface lif_tdm_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
);
  localparam int ID_W = $clog2(N_NEURONS);

  logic             in_valid;
  logic [ID_W-1:0]  in_addr;
  logic [WIDTH-1:0] in_current;
  logic             spike_valid;
  logic [ID_W-1:0]  spike_id;
  logic             spike_ready;

  modport master (
    output in_valid, in_addr, in_current, spike_ready,
    input  spike_valid, spike_id
  );

  modport slave (
    input  in_valid, in_addr, in_current, spike_ready,
    output spike_valid, spike_id
  );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// One leaky-integrate-and-fire datapath shared round-robin across N_NEURONS
// virtual neurons, with a small FIFO of fired neuron IDs on the output side.
module lif_tdm_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRAC     = 2,
  parameter int FIFO_DEPTH = 4   // power of 2, at least 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  lif_tdm_scheduler_if.slave           bus,
  output logic [WIDTH-1:0]             state_out,
  output logic [$clog2(N_NEURONS)-1:0] upd_id,
  output logic                         spk,
  output logic                         overflow
);
  localparam int ID_W = $clog2(N_NEURONS);
  localparam int RW   = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);

  localparam logic [WIDTH-1:0] VMAX        = '1;
  localparam logic [WIDTH-1:0] THR         = THRESHOLD[WIDTH-1:0];
  localparam logic [RW-1:0]    REFRAC_INIT = REFRAC[RW-1:0];
  localparam logic [PW:0]      FULL_COUNT  = FIFO_DEPTH[PW:0];

  // Per-neuron state
  logic [WIDTH-1:0] v_q      [N_NEURONS];
  logic [WIDTH-1:0] acc_q    [N_NEURONS];
  logic [RW-1:0]    refrac_q [N_NEURONS];
  logic [ID_W-1:0]  slot_q;

  // Spike event FIFO
  logic [ID_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW:0]      count_q;

  logic [WIDTH-1:0] v_cur;
  logic [WIDTH-1:0] v_leaked;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] sum_sat;
  logic [WIDTH:0]   acc_in_w;
  logic [WIDTH-1:0] acc_in_sat;
  logic             refrac_active;
  logic             fire;
  logic             full;
  logic             pop;
  logic             push;

  // NOTE: every signal below is assigned on every pass through the block,
  // so synthesis sees pure combinational logic and infers no latch.
  always_comb begin
    v_cur         = v_q[slot_q];
    v_leaked      = v_cur - (v_cur >> LEAK_SHIFT);
    sum_w         = {1'b0, v_leaked} + {1'b0, acc_q[slot_q]};
    sum_sat       = sum_w[WIDTH] ? VMAX : sum_w[WIDTH-1:0];
    acc_in_w      = {1'b0, acc_q[bus.in_addr]} + {1'b0, bus.in_current};
    acc_in_sat    = acc_in_w[WIDTH] ? VMAX : acc_in_w[WIDTH-1:0];
    refrac_active = (refrac_q[slot_q] != '0);
    fire          = enable && !refrac_active && (sum_sat >= THR);
    full          = (count_q == FULL_COUNT);
    pop           = (count_q != '0) && bus.spike_ready;
    // A full FIFO still takes the push when the head leaves on the same edge.
    push          = fire && (!full || pop);
  end

  // NOTE: the neuron register arrays are small flop banks, not RAM, and a
  // reset must discard all stored state, so every entry is cleared here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]      <= '0;
        acc_q[i]    <= '0;
        refrac_q[i] <= '0;
      end
      slot_q    <= '0;
      state_out <= '0;
      upd_id    <= '0;
      spk       <= 1'b0;
    end else begin
      spk <= 1'b0;

      // A visit consumes acc; a sample colliding with the visit becomes the
      // fresh acc so it is integrated on the next round.
      for (int i = 0; i < N_NEURONS; i++) begin
        if (enable && slot_q == ID_W'(i)) begin
          acc_q[i] <= (bus.in_valid && bus.in_addr == ID_W'(i)) ? bus.in_current : '0;
        end else if (bus.in_valid && bus.in_addr == ID_W'(i)) begin
          acc_q[i] <= acc_in_sat;
        end
      end

      if (enable) begin
        // NOTE: non-blocking assignments let every register sample the
        // pre-edge values, so the update reads the old v/acc/refrac.
        slot_q <= slot_q + ID_W'(1);
        upd_id <= slot_q;
        if (refrac_active) begin
          v_q[slot_q]      <= '0;
          refrac_q[slot_q] <= refrac_q[slot_q] - RW'(1);
          state_out        <= '0;
        end else if (fire) begin
          v_q[slot_q]      <= '0;
          refrac_q[slot_q] <= REFRAC_INIT;
          state_out        <= '0;
          spk              <= 1'b1;
        end else begin
          v_q[slot_q] <= sum_sat;
          state_out   <= sum_sat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= slot_q;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (PW+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PW+1)'(1);
      end
      if (fire && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.spike_valid = (count_q != '0);
  assign bus.spike_id    = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed bench for lif_tdm_scheduler: integration, leak, refractory,
// collision, FIFO full/overflow, accumulator saturation, enable and reset.
module tb_lif_tdm_scheduler;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] state_out;
  logic [1:0] upd_id;
  logic       spk;
  logic       overflow;

  int total_cnt = 0;
  int bad_cnt   = 0;

  lif_tdm_scheduler_if #(.N_NEURONS(4), .WIDTH(8)) bus ();

  lif_tdm_scheduler #(
    .N_NEURONS (4),
    .WIDTH     (8),
    .THRESHOLD (200),
    .LEAK_SHIFT(2),
    .REFRAC    (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .bus      (bus),
    .state_out(state_out),
    .upd_id   (upd_id),
    .spk      (spk),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge and land 1 ns after it, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample (or none) for exactly one edge.
  task automatic step(input logic vld, input logic [1:0] addr, input logic [7:0] cur);
    bus.in_valid   = vld;
    bus.in_addr    = addr;
    bus.in_current = cur;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_addr    = 2'd0;
    bus.in_current = 8'd0;
  endtask

  task automatic do_reset();
    enable          = 1'b0;
    bus.in_valid    = 1'b0;
    bus.spike_ready = 1'b0;
    reset_n         = 1'b0;
    #3;
    reset_n         = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_ids [4];

    reset_n         = 1'b0;
    enable          = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_addr     = 2'd0;
    bus.in_current  = 8'd0;
    bus.spike_ready = 1'b0;
    tick();
    tick();
    check("rst_state_out",   state_out,       0);
    check("rst_upd_id",      upd_id,          0);
    check("rst_spk",         spk,             0);
    check("rst_spike_valid", bus.spike_valid, 0);
    check("rst_spike_id",    bus.spike_id,    0);
    check("rst_overflow",    overflow,        0);
    reset_n = 1'b1;

    // Integration and leak on neuron 1
    enable = 1'b1;
    step(1'b1, 2'd1, 8'd120);                  // slot 0 updates, acc[1]=120
    check("int_first_upd", upd_id, 0);
    step(1'b0, 2'd0, 8'd0);                    // slot 1: 0 + 120
    check("int_state",  state_out, 120);
    check("int_upd_id", upd_id,    1);
    check("int_spk",    spk,       0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b1, 2'd2, 8'd250);                  // slot 1: 120 - 30; acc[2]=250
    check("leak_state",  state_out, 90);
    check("leak_upd_id", upd_id,    1);

    // Firing and refractory on neuron 2
    step(1'b0, 2'd0, 8'd0);                    // slot 2 fires
    check("fire_state",  state_out, 0);
    check("fire_spk",    spk,       1);
    check("fire_upd_id", upd_id,    2);
    step(1'b1, 2'd2, 8'd250);                  // slot 3; acc[2]=250
    check("fire_spk_pulse",   spk,             0);
    check("fire_spike_valid", bus.spike_valid, 1);
    check("fire_spike_id",    bus.spike_id,    2);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);                    // slot 2, refrac 2 -> 1
    check("refrac1_state", state_out, 0);
    check("refrac1_spk",   spk,       0);
    step(1'b1, 2'd2, 8'd250);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);                    // slot 2, refrac 1 -> 0
    check("refrac2_spk",    spk,    0);
    check("refrac2_upd_id", upd_id, 2);
    step(1'b1, 2'd2, 8'd250);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);                    // slot 2 fires again
    check("refire_spk",    spk,    1);
    check("refire_upd_id", upd_id, 2);

    // Collision of a sample with its own slot
    do_reset();
    enable = 1'b1;
    step(1'b1, 2'd0, 8'd150);                  // slot 0 uses old acc = 0
    check("coll_state",  state_out, 0);
    check("coll_upd_id", upd_id,    0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);                    // slot 0 integrates 150
    check("coll_next_state", state_out, 150);
    check("coll_next_spk",   spk,       0);

    // FIFO full: push with pop accepted, push without pop dropped
    do_reset();
    step(1'b1, 2'd0, 8'd250);                  // disabled: preload acc[0]
    enable = 1'b1;
    step(1'b1, 2'd1, 8'd250);                  // n0 fires, push 0
    check("ff_fire0", spk, 1);
    step(1'b1, 2'd2, 8'd250);                  // n1 fires, push 1
    step(1'b1, 2'd3, 8'd250);                  // n2 fires, push 2
    step(1'b0, 2'd0, 8'd0);                    // n3 fires, push 3 -> full
    check("ff_fire3_upd",  upd_id,          3);
    check("ff_fire3_spk",  spk,             1);
    check("ff_full_ovf",   overflow,        0);
    check("ff_full_valid", bus.spike_valid, 1);
    check("ff_full_head",  bus.spike_id,    0);
    step(1'b0, 2'd0, 8'd0);                    // n0 refractory visit
    check("ff_refrac_spk", spk, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 8'd0);
    step(1'b1, 2'd0, 8'd250);                  // slot 3; acc[0]=250
    bus.spike_ready = 1'b1;
    step(1'b1, 2'd1, 8'd250);                  // n0 fires, pop 0 + push 0
    bus.spike_ready = 1'b0;
    check("ff_pp_spk",  spk,          1);
    check("ff_pp_ovf",  overflow,     0);
    check("ff_pp_head", bus.spike_id, 1);
    step(1'b0, 2'd0, 8'd0);                    // n1 fires into full FIFO
    check("ff_drop_spk", spk,      1);
    check("ff_drop_ovf", overflow, 1);
    enable          = 1'b0;
    bus.spike_ready = 1'b1;
    exp_ids = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      check("ff_pop_valid", bus.spike_valid, 1);
      check("ff_pop_id",    bus.spike_id,    exp_ids[i]);
      tick();
    end
    check("ff_empty_valid",  bus.spike_valid, 0);
    check("ff_sticky_ovf",   overflow,        1);
    bus.spike_ready = 1'b0;

    // Accumulator saturation while disabled, then enable
    do_reset();
    step(1'b1, 2'd3, 8'd200);
    step(1'b1, 2'd3, 8'd200);
    step(1'b1, 2'd3, 8'd200);
    check("dis_upd_id", upd_id, 0);
    check("dis_spk",    spk,    0);
    enable = 1'b1;
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    check("sat_pre_upd", upd_id, 2);
    check("sat_pre_spk", spk,    0);
    step(1'b0, 2'd0, 8'd0);                    // n3: 255 >= 200
    check("sat_fire_upd", upd_id, 3);
    check("sat_fire_spk", spk,    1);
    enable = 1'b0;
    step(1'b0, 2'd0, 8'd0);
    check("hold_upd_id", upd_id, 3);
    check("hold_spk",    spk,    0);

    // Asynchronous reset with queued spikes and v[1] = 90
    do_reset();
    step(1'b1, 2'd0, 8'd250);
    step(1'b1, 2'd1, 8'd120);
    step(1'b1, 2'd2, 8'd250);
    enable = 1'b1;
    step(1'b0, 2'd0, 8'd0);                    // n0 fires
    check("mid_fire0", spk, 1);
    step(1'b0, 2'd0, 8'd0);                    // n1 = 120
    step(1'b0, 2'd0, 8'd0);                    // n2 fires
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0);                    // n1 = 90
    check("mid_state",  state_out,       90);
    check("mid_queued", bus.spike_valid, 1);
    reset_n = 1'b0;
    #2;
    check("arst_state_out",   state_out,       0);
    check("arst_upd_id",      upd_id,          0);
    check("arst_spk",         spk,             0);
    check("arst_spike_valid", bus.spike_valid, 0);
    check("arst_spike_id",    bus.spike_id,    0);
    check("arst_overflow",    overflow,        0);
    #1;
    reset_n = 1'b1;
    step(1'b0, 2'd0, 8'd0);
    check("post_upd_slot0", upd_id,          0);
    check("post_empty",     bus.spike_valid, 0);
    step(1'b0, 2'd0, 8'd0);
    check("post_n1_upd",   upd_id,    1);
    check("post_n1_state", state_out, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
